// File: rtl/attn_out_pkg.sv
// Shared types and sizing for the attention output collector.
// The output SRAM holds ROWS x GROUPS beats, one 128-bit word per beat.
package attn_out_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam int ROWS    = 4;
    localparam int GROUPS  = 32;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 128;
    localparam int ENTRIES = 128;
    localparam int CNT_W   = 8;

endpackage

// File: rtl/attn_out_bitmap.sv
// Occupancy bitmap for one collection pass.
// It reports whether the entry being set was already written, and counts distinct entries.
module attn_out_bitmap
    import attn_out_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    output logic              dup,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  count_next
);

    logic [ENTRIES-1:0] bits_r;
    logic [CNT_W-1:0]   count_r;
    logic               hit_s;
    logic               fresh_s;

    assign hit_s      = bits_r[set_idx];
    assign dup        = set_en & hit_s;
    assign count      = count_r;
    assign count_next = count_r + {{(CNT_W-1){1'b0}}, fresh_s};

    // A set adds a new entry only when the bit is clear; the count never passes ENTRIES.
    always_comb begin
        fresh_s = 1'b0;
        if (set_en && !hit_s && (count_r < CNT_W'(ENTRIES))) begin
            fresh_s = 1'b1;
        end else begin
            fresh_s = 1'b0;
        end
    end

    // Bitmap and counter state; clear has priority over a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_r  <= {ENTRIES{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            bits_r  <= {ENTRIES{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (fresh_s) begin
            bits_r[set_idx] <= 1'b1;
            count_r         <= count_next;
        end else begin
            bits_r  <= bits_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/attn_out_collector.sv
// Collects the attention output stream into the output SRAM, tracks coverage and errors,
// and serves fixed-latency host readback once the pass is complete.
module attn_out_collector
    import attn_out_pkg::*;
#(
    parameter int READ_LAT = 2,
    parameter int DATA_W   = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [1:0]        in_row,
    input  logic [4:0]        in_group,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_done,
    output logic              MEM_WEB,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DIN,
    input  logic [DATA_W-1:0] MEM_DOUT,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              all_written,
    output logic [CNT_W-1:0]  wr_count,
    output logic              err_dup,
    output logic              err_missing,
    output logic              err_unexp
);

    state_t              state_r;
    logic                busy_r;
    logic                all_written_r;
    logic                err_dup_r;
    logic                err_missing_r;
    logic                err_unexp_r;
    logic                mem_web_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_din_r;
    logic [READ_LAT-1:0] rd_pipe_r;

    logic                wr_accept_s;
    logic                count_en_s;
    logic                rd_ready_s;
    logic                rd_accept_s;
    logic                dup_s;
    logic [CNT_W-1:0]    count_s;
    logic [CNT_W-1:0]    count_next_s;

    // A beat that coincides with a restart still reaches the SRAM but belongs to no pass.
    assign wr_accept_s = (state_r == S_COLLECT) && in_valid;
    assign count_en_s  = wr_accept_s && !start;
    assign rd_ready_s  = (state_r == S_DONE) && mem_web_r;
    assign rd_accept_s = rd_req && rd_ready_s;

    attn_out_bitmap u_bitmap (
        .clk        (clk),
        .rst        (rst),
        .clr        (start),
        .set_en     (count_en_s),
        .set_idx    ({in_row, in_group}),
        .dup        (dup_s),
        .count      (count_s),
        .count_next (count_next_s)
    );

    // Pass control FSM with its registered status and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            busy_r        <= 1'b0;
            all_written_r <= 1'b0;
            err_dup_r     <= 1'b0;
            err_missing_r <= 1'b0;
            err_unexp_r   <= 1'b0;
        end else if (start) begin
            state_r       <= S_COLLECT;
            busy_r        <= 1'b1;
            all_written_r <= 1'b0;
            err_dup_r     <= 1'b0;
            err_missing_r <= 1'b0;
            err_unexp_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                S_COLLECT: begin
                    if (in_done) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= S_COLLECT;
                        busy_r  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r <= S_DONE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            all_written_r <= (count_next_s == CNT_W'(ENTRIES));
            err_dup_r     <= err_dup_r | (count_en_s & dup_s);
            err_missing_r <= err_missing_r | ((state_r == S_COLLECT) && in_done &&
                                              (count_next_s < CNT_W'(ENTRIES)));
            err_unexp_r   <= err_unexp_r | (in_valid && (state_r != S_COLLECT));
        end
    end

    // SRAM port: one-cycle write strobe per beat, read address on accept, address held when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_web_r  <= 1'b1;
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_din_r  <= {DATA_W{1'b0}};
        end else if (wr_accept_s) begin
            mem_web_r  <= 1'b0;
            mem_addr_r <= {in_row, in_group};
            mem_din_r  <= in_data;
        end else if (rd_accept_s) begin
            mem_web_r  <= 1'b1;
            mem_addr_r <= rd_addr;
        end else begin
            mem_web_r  <= 1'b1;
        end
    end

    // Read valid pipeline; in-flight reads drain even after the state changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe_r <= {READ_LAT{1'b0}};
        end else begin
            rd_pipe_r <= {rd_pipe_r[READ_LAT-2:0], rd_accept_s};
        end
    end

    assign MEM_WEB     = mem_web_r;
    assign MEM_ADDR    = mem_addr_r;
    assign MEM_DIN     = mem_din_r;
    assign rd_ready    = rd_ready_s;
    assign rd_valid    = rd_pipe_r[READ_LAT-1];
    assign rd_data     = rd_pipe_r[READ_LAT-1] ? MEM_DOUT : {DATA_W{1'b0}};
    assign busy        = busy_r;
    assign all_written = all_written_r;
    assign wr_count    = count_s;
    assign err_dup     = err_dup_r;
    assign err_missing = err_missing_r;
    assign err_unexp   = err_unexp_r;

endmodule

// File: doc/attn_out_collector.md
Name: attn_out_collector

Overview:
- Sink for the attention engine's output stream (valid, row, group, 128-bit data): 4 rows × 32 groups = 128 beats of 4×fp32.
- Writes each beat into a 128×128 output SRAM (same macro type as the projection memories), tracks which entries have been written, and reports completion and errors.
- After the pass is done, it serves host readback of the SRAM with fixed latency.
- Sits between the attention top and the chip-level result/readout port.

Parameters:
- READ_LAT, 2, cycles from the read-accept edge to rd_valid (1 address-register stage plus SRAM access); legal values are 2..4.
- DATA_W, 128, beat width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; begins a collection pass.
- in_valid  in  1  attention out_valid.
- in_row  in  2  attention out_row.
- in_group  in  5  attention out_group.
- in_data  in  128  attention out_data.
- in_done  in  1  attention done pulse.
- MEM_WEB  out  1  SRAM write enable, active-low.
- MEM_ADDR  out  7  SRAM address.
- MEM_DIN  out  128  SRAM write data.
- MEM_DOUT  in  128  SRAM Q.
- rd_req  in  1  host read request.
- rd_addr  in  7  host read address.
- rd_ready  out  1  read request can be accepted.
- rd_valid  out  1  rd_data is valid.
- rd_data  out  128  read data.
- busy  out  1  high while in S_COLLECT.
- all_written  out  1  all 128 entries written at least once in this pass.
- wr_count  out  8  number of distinct entries written (0..128).
- err_dup  out  1  sticky: an entry was written twice in one pass.
- err_missing  out  1  sticky: in_done arrived with wr_count < 128.
- err_unexp  out  1  sticky: in_valid arrived outside S_COLLECT.

Behaviour:
- Reset values: MEM_WEB=1, MEM_ADDR=0, MEM_DIN=0. Every other output is 0. State = S_IDLE. Bitmap is cleared. The read pipeline is flushed. Reset in the middle of a write or read aborts it with no further SRAM write.
- States:
  - S_IDLE: on start, go to S_COLLECT.
  - S_COLLECT: on in_done, go to S_DONE.
  - S_DONE: on start, go to S_COLLECT.
- Entering S_COLLECT clears the bitmap, wr_count, all_written and all three error flags.
- A start while already in S_COLLECT restarts the pass with the same clearing. A write beat registered in that same cycle is still issued to the SRAM but is not counted.
- Write path, S_COLLECT only:
  - in_valid sampled high at edge k → after edge k: MEM_WEB=0, MEM_ADDR={in_row,in_group}, MEM_DIN=in_data, for exactly one cycle. The SRAM commits at edge k+1.
  - Back-to-back beats every cycle are supported. There is no backpressure.
- Bitmap update for each accepted beat:
  - Bit clear: set it and increment wr_count.
  - Bit set: set err_dup; wr_count is unchanged; the data is still written (last write wins).
- all_written = (wr_count == 128), registered, so it is high in the cycle after the 128th distinct beat.
- in_done in S_COLLECT:
  - Same-cycle in_valid is still accepted and counted before the state transition.
  - err_missing is set if the count including that beat is < 128.
- in_valid outside S_COLLECT: the beat is dropped, no SRAM write, err_unexp is set.
- Read path:
  - rd_ready = (state == S_DONE) and no write pending in the register stage.
  - Accept when rd_req & rd_ready at edge k → after edge k: MEM_WEB=1, MEM_ADDR=rd_addr.
  - rd_valid is high in the cycle after edge k+READ_LAT−1, with rd_data = MEM_DOUT (a combinational pass-through, gated to 0 when rd_valid is low).
  - One read per cycle, fully pipelined.
  - rd_req in any other state is ignored. A read already in flight still completes after leaving S_DONE.
- Idle SRAM drive: MEM_WEB=1, MEM_ADDR holds its last value.
- Width rules:
  - wr_count saturates at 128; it cannot exceed 128 because duplicates are not counted.
  - Addresses wrap naturally in 7 bits; there is no out-of-range case.

Decomposition:
- Package attn_out_pkg holds:
  - state enum {S_IDLE, S_COLLECT, S_DONE};
  - constants ROWS=4, GROUPS=32, ADDR_W=7, DATA_W=128, ENTRIES=128.
- One sub-module, attn_out_bitmap: a 128-bit occupancy register with clear, a set/test port producing a dup flag, and the wr_count counter.
- The read-latency valid shift register stays inline.

Test Plan:
- Full pass: start, then 128 beats in row-major order with data = {4{addr}}, then in_done → wr_count=128, all_written=1, no errors, state S_DONE. Reading addresses 0..127 back-to-back returns rd_valid with rd_data = {4{addr}}, exactly READ_LAT cycles after each accept.
- Missing beats: start, 127 beats skipping row=2,group=5, then in_done → err_missing=1, wr_count=127, all_written=0. Reading address 69 returns the prior SRAM contents.
- Duplicate: row=1,group=3 is sent twice with data A then B → err_dup=1, wr_count increments only once, readback of address 35 = B.
- Unexpected and ignored traffic: in_valid in S_IDLE → err_unexp=1 and MEM_WEB stays 1. rd_req during S_COLLECT → rd_ready=0 and no rd_valid.
- Restart and reset: start again mid-pass after 40 beats → wr_count=0 and flags cleared. Assert rst asynchronously while MEM_WEB=0 → MEM_WEB=1 immediately, all outputs return to reset values.
- Simultaneous events: the last (128th) beat in the same cycle as in_done → counted, err_missing=0, all_written=1.
